// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the MDU E-stage sequencer.
//   - MD op codes as decoded in E (MDOP_*)
//   - HI/LO read select codes (RD_*)
//   - sequencer state encoding (ST_*)
//   - default MDU latencies and counter width
//   - small helpers to classify op codes
package mdu_pkg;

    localparam logic [3:0] MDOP_NONE  = 4'b0000;
    localparam logic [3:0] MDOP_MULT  = 4'b0001;
    localparam logic [3:0] MDOP_MULTU = 4'b0010;
    localparam logic [3:0] MDOP_DIV   = 4'b0011;
    localparam logic [3:0] MDOP_DIVU  = 4'b0100;
    localparam logic [3:0] MDOP_MTHI  = 4'b0101;
    localparam logic [3:0] MDOP_MTLO  = 4'b0110;

    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_LO   = 2'b01;
    localparam logic [1:0] RD_HI   = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MULT_TIME_DEF = 5;
    localparam int DIV_TIME_DEF  = 10;
    localparam int CNT_W_DEF     = 4;

    // Ops that occupy the MDU (everything else is a pass-through).
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_decode.sv
// mdu_ctrl_decode: purely combinational decode of the E-stage MD instruction.
// Ports:
//   e_valid_i     E stage holds a real instruction
//   e_mduop_i     decoded MD op of the E instruction
//   e_readhilo_i  E instruction HI/LO read select
//   mduop_o       op forwarded to the MDU (zero for bubbles)
//   time_o        MDU latency for this op (zero unless mult/div)
//   start_req_o   E instruction wants to start the MDU
//   readhilo_o    HI/LO read select forwarded to the MDU
module mdu_ctrl_decode
    import mdu_pkg::*;
#(
    parameter int MULT_TIME = MULT_TIME_DEF,
    parameter int DIV_TIME  = DIV_TIME_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             e_valid_i,
    input  logic [3:0]       e_mduop_i,
    input  logic [1:0]       e_readhilo_i,
    output logic [3:0]       mduop_o,
    output logic [CNT_W-1:0] time_o,
    output logic             start_req_o,
    output logic [1:0]       readhilo_o
);

    always_comb begin
        mduop_o     = MDOP_NONE;
        time_o      = '0;
        start_req_o = 1'b0;
        readhilo_o  = RD_NONE;
        if (e_valid_i) begin
            // Illegal codes are forwarded untouched but never request a start.
            mduop_o    = e_mduop_i;
            readhilo_o = e_readhilo_i;
            if (is_mul_op(e_mduop_i)) begin
                time_o      = CNT_W'(MULT_TIME);
                start_req_o = 1'b1;
            end else if (is_div_op(e_mduop_i)) begin
                time_o      = CNT_W'(DIV_TIME);
                start_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage sequencer for the multiply/divide unit.
// Decodes the E-stage MD instruction into the MDU control bundle, tracks
// MDU occupancy with its own down-counter, stalls MD-class instructions in
// D while the unit is occupied, and cross-checks its view against MDU_Busy.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   E_Valid         E stage holds a real instruction
//   E_MDUOP         decoded MD op of the E instruction
//   E_ReadHILO      HI/LO read select of the E instruction
//   D_IsMD          D-stage instruction is MD-class
//   MDU_Busy        busy indication from the MDU
//   Start           one-cycle MDU start (combinational)
//   MDUOP, Time     op and latency to the MDU (combinational)
//   ReadHILO        HI/LO read select to the MDU (combinational)
//   Stall           freeze F/D, bubble into E
//   SyncErr         sticky: counter and MDU_Busy disagree
//   StallCycles     (MDU_CTRL_PERF_EN only) saturating count of stalled cycles
//   Issued          (MDU_CTRL_PERF_EN only) saturating count of starts
//
// Build option: define MDU_CTRL_PERF_EN to add the performance counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | MDU free; a mult/div in E starts it this cycle
// RUN   | MDU computing; cnt holds remaining cycles, reaches IDLE at cnt==1
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_TIME = MULT_TIME_DEF,
    parameter int DIV_TIME  = DIV_TIME_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_Valid,
    input  logic [3:0]       E_MDUOP,
    input  logic [1:0]       E_ReadHILO,
    input  logic             D_IsMD,
    input  logic             MDU_Busy,
    output logic             Start,
    output logic [3:0]       MDUOP,
    output logic [CNT_W-1:0] Time,
    output logic [1:0]       ReadHILO,
    output logic             Stall,
    output logic             SyncErr
`ifdef MDU_CTRL_PERF_EN
    ,
    output logic [31:0]      StallCycles,
    output logic [31:0]      Issued
`endif
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_err_q, sync_err_d;
    logic             start_req;
    logic             in_run;

    mdu_ctrl_decode #(
        .MULT_TIME (MULT_TIME),
        .DIV_TIME  (DIV_TIME),
        .CNT_W     (CNT_W)
    ) u_decode (
        .e_valid_i    (E_Valid),
        .e_mduop_i    (E_MDUOP),
        .e_readhilo_i (E_ReadHILO),
        .mduop_o      (MDUOP),
        .time_o       (Time),
        .start_req_o  (start_req),
        .readhilo_o   (ReadHILO)
    );

    assign in_run = (state_q == ST_RUN);

    // A start request while already running is never honoured; it is only
    // reachable if the D-stage stall was bypassed, and the checker flags it.
    assign Start = start_req & ~in_run;
    assign Stall = D_IsMD & (Start | in_run);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    cnt_d   = Time;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The MDU raises Busy in the Start cycle itself, so idle-with-Busy is
    // only legal when we are starting it this very cycle.
    always_comb begin
        sync_err_d = sync_err_q
                   | (~in_run & ~Start & MDU_Busy)
                   | (in_run & ~MDU_Busy)
                   | (in_run & start_req);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign SyncErr = sync_err_q;

`ifdef MDU_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] issued_q, issued_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        issued_d    = issued_q;
        if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (Start && (issued_q != 32'hFFFF_FFFF)) begin
            issued_d = issued_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            issued_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            issued_q    <= issued_d;
        end
    end

    assign StallCycles = stall_cnt_q;
    assign Issued      = issued_q;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: a driver issues one cycle of stimulus at a time and
// pushes the expected outputs for that cycle, computed from an occupancy
// window model (absolute end cycle of the current MDU operation). A monitor
// on the falling edge pops and compares whatever the DUT presents.
module tb_mdu_ctrl;

    localparam int MT = 5;
    localparam int DT = 10;

    logic        clk;
    logic        reset;
    logic        E_Valid;
    logic [3:0]  E_MDUOP;
    logic [1:0]  E_ReadHILO;
    logic        D_IsMD;
    logic        MDU_Busy;
    logic        Start;
    logic [3:0]  MDUOP;
    logic [3:0]  Time;
    logic [1:0]  ReadHILO;
    logic        Stall;
    logic        SyncErr;
`ifdef MDU_CTRL_PERF_EN
    logic [31:0] StallCycles;
    logic [31:0] Issued;
`endif

    mdu_ctrl #(.MULT_TIME(MT), .DIV_TIME(DT), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_Valid    (E_Valid),
        .E_MDUOP    (E_MDUOP),
        .E_ReadHILO (E_ReadHILO),
        .D_IsMD     (D_IsMD),
        .MDU_Busy   (MDU_Busy),
        .Start      (Start),
        .MDUOP      (MDUOP),
        .Time       (Time),
        .ReadHILO   (ReadHILO),
        .Stall      (Stall),
        .SyncErr    (SyncErr)
`ifdef MDU_CTRL_PERF_EN
        ,
        .StallCycles(StallCycles),
        .Issued     (Issued)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         chk;
        logic       start;
        logic [3:0] op;
        logic [3:0] tm;
        logic [1:0] rd;
        logic       stall;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int          cyc      = 0;
    int          busy_end = -1;   // last cycle the MDU is occupied by RUN
    bit          m_err    = 1'b0;
    int unsigned m_stalls = 0;
    int unsigned m_issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                check("Start",    32'(Start),    32'(e.start));
                check("MDUOP",    32'(MDUOP),    32'(e.op));
                check("Time",     32'(Time),     32'(e.tm));
                check("ReadHILO", 32'(ReadHILO), 32'(e.rd));
                check("Stall",    32'(Stall),    32'(e.stall));
                check("SyncErr",  32'(SyncErr),  32'(e.err));
            end
        end
    end

    // One cycle of stimulus. force_busy: -1 = well-behaved MDU, 0/1 = forced.
    task automatic step(input bit v, input logic [3:0] op, input logic [1:0] rd,
                        input bit dmd, input bit rst, input bit chk,
                        input int force_busy);
        exp_t e;
        bit   req, running, st, busy, stl;
        int   tm;
        @(posedge clk);
        #1;
        tm      = !v ? 0 : (op == 4'd1 || op == 4'd2) ? MT : (op == 4'd3 || op == 4'd4) ? DT : 0;
        req     = v && (op >= 4'd1) && (op <= 4'd4);
        running = (cyc <= busy_end);
        st      = req && !running;
        busy    = (force_busy < 0) ? (st || running) : (force_busy != 0);
        stl     = dmd && (st || running);

        reset      = rst;
        E_Valid    = v;
        E_MDUOP    = op;
        E_ReadHILO = rd;
        D_IsMD     = dmd;
        MDU_Busy   = busy;

        e.chk   = chk;
        e.start = st;
        e.op    = v ? op : 4'd0;
        e.tm    = 4'(tm);
        e.rd    = v ? rd : 2'd0;
        e.stall = stl;
        e.err   = m_err;
        exp_q.push_back(e);

        if (rst) begin
            busy_end = cyc;
            m_err    = 1'b0;
            m_stalls = 0;
            m_issued = 0;
        end else begin
            if ((!running && !st && busy) || (running && !busy) || (running && req))
                m_err = 1'b1;
            if (st) busy_end = cyc + tm;
            if (stl && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            if (st && m_issued != 32'hFFFF_FFFF) m_issued++;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit dmd);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 2'd0, dmd, 1'b0, 1'b1, -1);
    endtask

    initial begin
        reset = 1'b1; E_Valid = 1'b0; E_MDUOP = '0; E_ReadHILO = '0;
        D_IsMD = 1'b0; MDU_Busy = 1'b0;

        // Reset; first cycle's outputs depend on pre-reset state
        step(1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, -1);
        step(1'b0, 4'd0, 2'd0, 1'b1, 1'b1, 1'b1, -1);
        idle(1, 1'b1);

        // mult with an MD instruction waiting in D: 1 + 5 stalled cycles
        step(1'b1, 4'd1, 2'd0, 1'b1, 1'b0, 1'b1, -1);
        idle(MT, 1'b1);
        idle(1, 1'b1);

        // divu, then mflo released from D
        step(1'b1, 4'd4, 2'd0, 1'b1, 1'b0, 1'b1, -1);
        idle(DT, 1'b1);
        step(1'b1, 4'd0, 2'b01, 1'b0, 1'b0, 1'b1, -1);

        // mthi while idle; mtlo held in D behind a mult
        step(1'b1, 4'd5, 2'd0, 1'b0, 1'b0, 1'b1, -1);
        step(1'b1, 4'd1, 2'd0, 1'b1, 1'b0, 1'b1, -1);
        idle(MT, 1'b1);
        step(1'b1, 4'd6, 2'd0, 1'b0, 1'b0, 1'b1, -1);

        // Bubble carrying a mult code, and an illegal code
        step(1'b0, 4'd1, 2'b10, 1'b0, 1'b0, 1'b1, -1);
        step(1'b1, 4'd9, 2'b10, 1'b0, 1'b0, 1'b1, -1);

        // Reset in the third RUN cycle of a div, then a clean mult
        step(1'b1, 4'd3, 2'd0, 1'b1, 1'b0, 1'b1, -1);
        idle(2, 1'b1);
        step(1'b0, 4'd0, 2'd0, 1'b1, 1'b1, 1'b1, -1);
        idle(1, 1'b1);
        step(1'b1, 4'd2, 2'd0, 1'b1, 1'b0, 1'b1, -1);
        idle(MT + 1, 1'b1);

        // Busy dropped mid-RUN: error sets and stays until reset
        step(1'b1, 4'd1, 2'd0, 1'b0, 1'b0, 1'b1, -1);
        step(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 0);
        idle(8, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, -1);
        idle(1, 1'b0);

        // Start request arriving while running, and spurious Busy while idle
        step(1'b1, 4'd3, 2'd0, 1'b0, 1'b0, 1'b1, -1);
        step(1'b1, 4'd1, 2'd0, 1'b0, 1'b0, 1'b1, -1);
        idle(DT + 1, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, -1);
        step(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1);
        idle(2, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, -1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit         v, dmd, rst;
            logic [3:0] op;
            logic [1:0] rd;
            int         fb;
            v   = ($urandom_range(0, 4) != 0);
            op  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15));
            rd  = 2'($urandom_range(0, 3));
            dmd = ($urandom_range(0, 1) != 0);
            rst = ($urandom_range(0, 59) == 0);
            fb  = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 1)) : -1;
            step(v, op, rd, dmd, rst, 1'b1, fb);
        end

        idle(DT + 2, 1'b1);
        @(posedge clk);
        #1;
`ifdef MDU_CTRL_PERF_EN
        check("StallCycles", StallCycles, m_stalls);
        check("Issued", Issued, m_issued);
        // Short fresh window: two mults, one stalled start+RUN window
        step(1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, -1);
        step(1'b1, 4'd1, 2'd0, 1'b0, 1'b0, 1'b1, -1);
        idle(MT, 1'b0);
        step(1'b1, 4'd2, 2'd0, 1'b1, 1'b0, 1'b1, -1);
        idle(MT - 1, 1'b1);
        idle(2, 1'b0);
        @(posedge clk);
        #1;
        check("Issued2", Issued, 32'd2);
        check("StallCycles2", StallCycles, 32'(MT));
`endif
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- E-stage sequencer for the pipeline's multiply/divide unit (MDU). Decodes the E-stage MD-class instruction into the MDU control bundle: Start pulse, op code, latency and HI/LO read select.
- Tracks MDU occupancy with its own cycle counter and raises the D-stage stall for any MD-class instruction while the unit is occupied.
- Cross-checks its counter against the MDU's Busy and flags any disagreement.

Parameters:
- MULT_TIME, 5, MDU latency in cycles for mult/multu; must be >= 2.
- DIV_TIME, 10, MDU latency in cycles for div/divu; must be >= 2.
- CNT_W, 4, width of Time and of the internal counter; must hold max(MULT_TIME, DIV_TIME).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- E_Valid  in  1  E stage holds a real instruction (0 = bubble or flushed).
- E_MDUOP  in  4  decoded MD op of E instr: 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo; anything else = none.
- E_ReadHILO  in  2  E instr reads HI/LO: 01 mflo, 10 mfhi, 00 none.
- D_IsMD  in  1  D-stage instr is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- MDU_Busy  in  1  Busy from the MDU.
- Start  out  1  one-cycle MDU start, combinational.
- MDUOP  out  4  op to MDU, combinational.
- Time  out  CNT_W  latency to MDU, combinational.
- ReadHILO  out  2  HI/LO read select to MDU, combinational.
- Stall  out  1  freeze F/D, bubble into E.
- SyncErr  out  1  sticky: counter and MDU_Busy disagree.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high. Reset forces state IDLE, cnt = 0, SyncErr = 0.
- Decode (all gated by E_Valid):
  - Start = E_Valid & (E_MDUOP in 0001..0100) & (state == IDLE).
  - MDUOP = E_Valid ? E_MDUOP : 0000. Illegal codes (0000, 0111..1111) pass through but never start.
  - Time = MULT_TIME for 0001/0010, DIV_TIME for 0011/0100, else 0.
  - ReadHILO = E_Valid ? E_ReadHILO : 00.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on Start; load cnt <= Time.
  - RUN: cnt <= cnt - 1 each cycle. RUN -> IDLE when cnt == 1, so RUN lasts exactly Time cycles.
  - Total occupancy is Start cycle + Time cycles, matching the MDU's Busy window.
- Stall = D_IsMD & (Start | state == RUN).
  - Any MD-class instruction is held in D through the whole occupancy, including the Start cycle.
  - A non-MD instruction never stalls.
  - Consequence: an E-stage start while in RUN is unreachable in correct operation. If it occurs anyway, Start stays 0 and SyncErr sets.
- mthi/mtlo: MDUOP is forwarded, Start = 0, no state change. They are stalled in D while RUN, so they never overwrite HI/LO mid-operation.
- Divide by zero: no special case. Full DIV_TIME is used; result is whatever the MDU produces.
- SyncErr sets (sticky until reset) on any of:
  - state == IDLE & !Start & MDU_Busy.
  - state == RUN & !MDU_Busy.
  - E-stage start request while in RUN.
- Reset mid-RUN: state returns to IDLE next edge and Stall drops immediately after. The MDU is reset by the same signal.
- E_Valid = 0 while in RUN does not disturb the countdown.

Optional Feature:
- Macro: MDU_CTRL_PERF_EN.
- Defined: adds output StallCycles (32) and output Issued (32).
  - StallCycles increments each cycle Stall = 1; Issued increments each Start.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package mdu_pkg holds:
  - MD op codes (MDOP_MULT = 4'b0001 ... MDOP_MTLO = 4'b0110, MDOP_NONE = 4'b0000).
  - HI/LO select codes (RD_NONE = 2'b00, RD_LO = 2'b01, RD_HI = 2'b10).
  - FSM state encoding.
  - Default latencies.
- One natural sub-module, mdu_ctrl_decode: purely combinational E-stage decode (MDUOP, Time, start request, ReadHILO). The FSM, counter, stall and checker stay in mdu_ctrl.

Test Plan:
- mult: E_Valid = 1, E_MDUOP = 0001, MDU_Busy modelled. Required: Start for 1 cycle, Time = 5. Then D_IsMD = 1 yields Stall for 6 consecutive cycles (Start + 5 RUN), then 0. SyncErr stays 0.
- divu followed by mflo in D: Start, Time = 10. Stall for 11 cycles. On release, mflo issues with ReadHILO = 01 and Start = 0.
- mthi while IDLE: MDUOP = 0101, Start = 0, Time = 0, state stays IDLE. mtlo in D during a mult RUN is stalled until state returns to IDLE.
- Bubble/illegal: E_Valid = 0 with E_MDUOP = 0001 gives MDUOP = 0 and Start = 0. E_MDUOP = 1001 with E_Valid = 1 gives Start = 0 and Time = 0.
- Reset at cycle 3 of a div RUN: next edge state IDLE, Stall = 0 with D_IsMD = 1. A following mult starts normally with Time = 5.
- Checker: force MDU_Busy = 0 during RUN gives SyncErr = 1 next edge, held until reset. With MDU_CTRL_PERF_EN, two mults with 5 stalled cycles read Issued = 2 and StallCycles = 5.
